// File: rtl/if_stage.sv
// if_stage: PC, instruction fetch FSM and IF/ID register; define IF_STALL_CNT_EN for the stall counter
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             IFIDWrite,
    input  logic             Branch_Taken,
    input  logic [31:0]      Branch_Target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_valid,
    output logic [31:0]      IFID_Instr,
    output logic [31:0]      IFID_PC4,
    output logic             IFID_Valid,
    output logic [4:0]       IFID_RS,
    output logic [4:0]       IFID_RT,
    output logic [5:0]       Op,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {BOOT, RUN, MISS} state_t;
    state_t      state_q, state_d;
    logic        req_q, req_d, valid_q, valid_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
    logic        fetch_ok, hold;
    logic [31:0] pc_plus4;
    assign fetch_ok = req_q & imem_valid;
    assign hold     = !PCWrite || !IFIDWrite;
    assign pc_plus4 = pc_q + 32'd4;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else begin
            state_d = (imem_valid || Branch_Taken) ? RUN : MISS;
            if (Branch_Taken) begin
                pc_d    = {Branch_Target[31:2], 2'b00};
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end else if (hold || !fetch_ok) begin
                // a hold or miss discards the fetched word; bubble only if IF/ID may move
                if (IFIDWrite) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end else begin
                pc_d    = pc_plus4;
                instr_d = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
        req_d = state_d != BOOT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            req_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end
    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign IFID_Instr = instr_q;
    assign IFID_PC4   = pc4_q;
    assign IFID_Valid = valid_q;
    assign IFID_RS    = instr_q[25:21];
    assign IFID_RT    = instr_q[20:16];
    assign Op         = instr_q[31:26];
`ifdef IF_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = (state_q != BOOT && !Branch_Taken && (!PCWrite || state_q == MISS) && cnt_q != '1)
                ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus random checks of if_stage against a behavioural fetch model
module tb_if_stage;
    logic        clk = 0, rst = 1;
    logic        PCWrite = 1, IFIDWrite = 1, Branch_Taken = 0, imem_valid = 1;
    logic [31:0] Branch_Target = 0;
    logic        imem_req, IFID_Valid;
    logic [31:0] imem_addr, imem_rdata, IFID_Instr, IFID_PC4;
    logic [4:0]  IFID_RS, IFID_RT;
    logic [5:0]  Op;
    logic [15:0] stall_count;
    int checks = 0, failures = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction
    assign imem_rdata = word_at(imem_addr);
    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .IFID_Instr(IFID_Instr), .IFID_PC4(IFID_PC4),
        .IFID_Valid(IFID_Valid), .IFID_RS(IFID_RS), .IFID_RT(IFID_RT), .Op(Op),
        .stall_count(stall_count)
    );

    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid, m_pc4_chk, m_boot, m_miss;
    int          m_cnt;

    task automatic m_reset;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_pc4_chk = 1;
        m_boot = 1; m_miss = 0; m_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"}, 32'(imem_req), 32'(!m_boot));
        chk({tag, ".addr"}, imem_addr, m_pc);
        chk({tag, ".instr"}, IFID_Instr, m_instr);
        chk({tag, ".valid"}, 32'(IFID_Valid), 32'(m_valid));
        if (m_pc4_chk) chk({tag, ".pc4"}, IFID_PC4, m_pc4);
        chk({tag, ".rs"}, 32'(IFID_RS), 32'((m_instr >> 21) & 32'h1F));
        chk({tag, ".rt"}, 32'(IFID_RT), 32'((m_instr >> 16) & 32'h1F));
        chk({tag, ".op"}, 32'(Op), m_instr >> 26);
`ifdef IF_STALL_CNT_EN
        chk({tag, ".cnt"}, 32'(stall_count), 32'(m_cnt));
`else
        chk({tag, ".cnt"}, 32'(stall_count), 32'd0);
`endif
    endtask

    // Advance the model by the rules for the inputs now applied, then clock and compare.
    task automatic tick(input string tag);
        if (m_boot) m_boot = 0;
        else begin
            if (!Branch_Taken && (!PCWrite || m_miss) && m_cnt < 65535) m_cnt++;
            if (Branch_Taken) begin
                m_pc = Branch_Target & ~32'h3;
                m_instr = 0; m_pc4 = 0; m_valid = 0; m_pc4_chk = 1; m_miss = 0;
            end else begin
                if (!PCWrite || !IFIDWrite || !imem_valid) begin
                    if (IFIDWrite) begin m_instr = 0; m_valid = 0; m_pc4_chk = 0; end
                end else begin
                    m_instr = word_at(m_pc); m_pc4 = m_pc + 4; m_pc = m_pc + 4;
                    m_valid = 1; m_pc4_chk = 1;
                end
                m_miss = !imem_valid;
            end
        end
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic run_to(input logic [31:0] a);
        for (int i = 0; i < 64 && m_pc != a; i++) tick("run");
        chk("reach", imem_addr, a);
    endtask

    initial begin
        m_reset();
        #12 check_all("reset");
        @(posedge clk); #1 rst = 0;
        check_all("reset_rel");
        tick("boot");
        chk("boot_addr", imem_addr, 32'h0);
        tick("fetch0");
        chk("first_pc4", IFID_PC4, 32'h4);
        chk("first_valid", 32'(IFID_Valid), 32'd1);
        tick("fetch1");
        chk("third_addr", imem_addr, 32'h8);

        run_to(32'h10);
        PCWrite = 0; IFIDWrite = 0;
        tick("stall0");
        tick("stall1");
        chk("stall_addr", imem_addr, 32'h10);
        chk("stall_pc4", IFID_PC4, 32'h10);
        PCWrite = 1; IFIDWrite = 1;
        tick("resume");
        chk("resume_pc4", IFID_PC4, 32'h14);

        run_to(32'h20);
        imem_valid = 0;
        tick("miss0"); tick("miss1"); tick("miss2");
        chk("miss_addr", imem_addr, 32'h20);
        chk("miss_op", 32'(Op), 32'd0);
        imem_valid = 1;
        tick("miss_done");
        chk("miss_pc4", IFID_PC4, 32'h24);

        IFIDWrite = 0; Branch_Taken = 1; Branch_Target = 32'h100;
        tick("br_stall");
        chk("br_addr", imem_addr, 32'h100);
        chk("br_flush", IFID_Instr, 32'h0);
        IFIDWrite = 1; Branch_Taken = 0;
        tick("br_tgt");
        chk("br_tgt_pc4", IFID_PC4, 32'h104);
        Branch_Taken = 1; Branch_Target = 32'h103;
        tick("br_align");
        chk("br_align_addr", imem_addr, 32'h100);
        Branch_Target = 32'hFFFF_FFFC;
        tick("br_top");
        Branch_Taken = 0;
        tick("wrap");
        chk("wrap_addr", imem_addr, 32'h0);

        for (int i = 0; i < 400; i++) begin
            imem_valid    = $urandom_range(0, 3) != 0;
            PCWrite       = $urandom_range(0, 6) != 0;
            IFIDWrite     = $urandom_range(0, 6) != 0;
            Branch_Taken  = $urandom_range(0, 9) == 0;
            Branch_Target = $urandom;
            tick("rand");
        end

        PCWrite = 1; IFIDWrite = 1; Branch_Taken = 0; imem_valid = 0;
        tick("pre_miss0");
        tick("pre_miss1");
        #3 rst = 1;
        #1 m_reset();
        check_all("async_rst");
        chk("async_cnt", 32'(stall_count), 32'd0);
        @(posedge clk); #1 rst = 0; imem_valid = 1;
        tick("post_boot");
        tick("post_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
